// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences privileged TLB instructions onto the TLB array ports
// Entry layout (89 bits): [88]=e [87:78]=asid [77]=g [76:71]=ps [70:52]=vppn [51:26]=page0 [25:0]=page1
module tlb_op_ctrl #(
    parameter int TLBNUM = 32,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_op_valid,
    output logic          o_op_ready,
    input  logic [2:0]    i_op_code,
    input  logic [IW-1:0] i_op_index,
    input  logic [88:0]   i_op_entry,
    input  logic [4:0]    i_op_inv_op,
    input  logic [9:0]    i_op_inv_asid,
    input  logic [18:0]   i_op_inv_vpn,
    output logic          o_resp_valid,
    output logic          o_resp_found,
    output logic [IW-1:0] o_resp_index,
    output logic [88:0]   o_resp_entry,
    output logic          o_resp_err,
    input  logic          i_dmmu_fetch,
    input  logic [18:0]   i_dmmu_vppn,
    input  logic          i_dmmu_odd_page,
    input  logic [9:0]    i_dmmu_asid,
    output logic          o_dmmu_stall,
    output logic          o_s1_fetch,
    output logic [18:0]   o_s1_vppn,
    output logic          o_s1_odd_page,
    output logic [9:0]    o_s1_asid,
    input  logic          i_s1_found,
    input  logic [IW-1:0] i_s1_index,
    output logic          o_we,
    output logic [IW-1:0] o_w_index,
    output logic [88:0]   o_write_port,
    output logic [IW-1:0] o_r_index,
    input  logic [88:0]   i_read_port,
    output logic          o_inv_en,
    output logic [4:0]    o_inv_op,
    output logic [9:0]    o_inv_asid,
    output logic [18:0]   o_inv_vpn
);
    typedef enum logic [2:0] {S_IDLE, S_SRCH, S_SRCH_WAIT, S_RD, S_WR, S_INV, S_RESP} state_t;
    state_t        r_state, w_next;
    logic [2:0]    r_code;
    logic [IW-1:0] r_index, r_fill, r_fill_smp, r_resp_index;
    logic [88:0]   r_entry, r_resp_entry;
    logic [4:0]    r_inv_op;
    logic [9:0]    r_inv_asid;
    logic [18:0]   r_inv_vpn;
    logic          r_resp_found, r_resp_err;
    logic          w_accept, w_srch;
    logic [IW-1:0] w_windex;

    assign w_accept = i_op_valid && r_state == S_IDLE;
    assign w_srch   = r_state == S_SRCH;
    assign w_windex = r_code == 3'd3 ? r_fill_smp : r_index;

    // state register, operand latch, replacement counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_code       <= '0;
            r_index      <= '0;
            r_entry      <= '0;
            r_inv_op     <= '0;
            r_inv_asid   <= '0;
            r_inv_vpn    <= '0;
            r_fill       <= '0;
            r_fill_smp   <= '0;
            r_resp_found <= 1'b0;
            r_resp_index <= '0;
            r_resp_entry <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_fill  <= r_fill == IW'(TLBNUM - 1) ? '0 : r_fill + 1'b1;
            if (w_accept) begin
                r_code       <= i_op_code;
                r_index      <= i_op_index;
                r_entry      <= i_op_entry;
                r_inv_op     <= i_op_inv_op;
                r_inv_asid   <= i_op_inv_asid;
                r_inv_vpn    <= i_op_inv_vpn;
                r_fill_smp   <= r_fill;
                r_resp_found <= 1'b0;
                r_resp_index <= '0;
                r_resp_entry <= '0;
                r_resp_err   <= i_op_code > 3'd4;
            end
            if (r_state == S_SRCH_WAIT) begin
                r_resp_found <= i_s1_found;
                r_resp_index <= i_s1_found ? i_s1_index : '0;
            end
            if (r_state == S_RD)
                r_resp_entry <= i_read_port;
            if (r_state == S_WR)
                r_resp_index <= w_windex;
            if (r_state == S_INV)
                r_resp_err <= r_inv_op > 5'd6;
        end
    end

    // next-state: every op funnels through RESP back to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (i_op_valid)
                             w_next = i_op_code == 3'd0 ? S_SRCH :
                                      i_op_code == 3'd1 ? S_RD :
                                      i_op_code == 3'd2 || i_op_code == 3'd3 ? S_WR :
                                      i_op_code == 3'd4 ? S_INV : S_RESP;
            S_SRCH:      w_next = S_SRCH_WAIT;
            S_RESP:      w_next = S_IDLE;
            default:     w_next = S_RESP;
        endcase
    end

    assign o_op_ready    = r_state == S_IDLE;
    assign o_resp_valid  = r_state == S_RESP;
    assign o_resp_found  = r_resp_found;
    assign o_resp_index  = r_resp_index;
    assign o_resp_entry  = r_resp_entry;
    assign o_resp_err    = r_resp_err;
    assign o_dmmu_stall  = w_srch || r_state == S_SRCH_WAIT;
    assign o_s1_fetch    = w_srch ? 1'b1 : r_state == S_SRCH_WAIT ? 1'b0 : i_dmmu_fetch;
    assign o_s1_vppn     = w_srch ? r_entry[70:52] : i_dmmu_vppn;
    assign o_s1_asid     = w_srch ? r_entry[87:78] : i_dmmu_asid;
    assign o_s1_odd_page = w_srch ? 1'b0 : i_dmmu_odd_page;
    assign o_we          = r_state == S_WR;
    assign o_w_index     = w_windex;
    assign o_write_port  = r_entry;
    assign o_r_index     = r_index;
    assign o_inv_en      = r_state == S_INV && r_inv_op <= 5'd6;
    assign o_inv_op      = r_inv_op;
    assign o_inv_asid    = r_inv_asid;
    assign o_inv_vpn     = r_inv_vpn;
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: vector table, corner sequences and random ops against a TLB reference model
module tb_tlb_op_ctrl;
    logic        clk = 0, rst;
    logic        op_valid, op_ready;
    logic [2:0]  op_code;
    logic [4:0]  op_index;
    logic [88:0] op_entry;
    logic [4:0]  inv_op_i;
    logic [9:0]  inv_asid_i;
    logic [18:0] inv_vpn_i;
    logic        resp_valid, resp_found, resp_err;
    logic [4:0]  resp_index;
    logic [88:0] resp_entry;
    logic        dmmu_fetch, dmmu_odd, dmmu_stall;
    logic [18:0] dmmu_vppn;
    logic [9:0]  dmmu_asid;
    logic        s1_fetch, s1_odd, s1_found;
    logic [18:0] s1_vppn;
    logic [9:0]  s1_asid;
    logic [4:0]  s1_index;
    logic        we;
    logic [4:0]  w_index, r_index;
    logic [88:0] write_port, read_port;
    logic        inv_en;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vpn;

    int errors = 0, checks = 0, cyc = 0;
    logic [88:0] mem [32];
    logic [88:0] ref_mem [32];

    typedef struct {
        logic [2:0] code; logic [4:0] idx; logic [88:0] ent;
        logic [4:0] iop; logic [9:0] iasid; logic [18:0] ivpn;
        int lat; bit found; logic [4:0] ridx; bit err; logic [88:0] rent; int nwe; int ninv;
    } vec_t;

    tlb_op_ctrl #(.TLBNUM(32)) dut (
        .clk(clk), .rst(rst),
        .i_op_valid(op_valid), .o_op_ready(op_ready), .i_op_code(op_code), .i_op_index(op_index),
        .i_op_entry(op_entry), .i_op_inv_op(inv_op_i), .i_op_inv_asid(inv_asid_i), .i_op_inv_vpn(inv_vpn_i),
        .o_resp_valid(resp_valid), .o_resp_found(resp_found), .o_resp_index(resp_index),
        .o_resp_entry(resp_entry), .o_resp_err(resp_err),
        .i_dmmu_fetch(dmmu_fetch), .i_dmmu_vppn(dmmu_vppn), .i_dmmu_odd_page(dmmu_odd),
        .i_dmmu_asid(dmmu_asid), .o_dmmu_stall(dmmu_stall),
        .o_s1_fetch(s1_fetch), .o_s1_vppn(s1_vppn), .o_s1_odd_page(s1_odd), .o_s1_asid(s1_asid),
        .i_s1_found(s1_found), .i_s1_index(s1_index),
        .o_we(we), .o_w_index(w_index), .o_write_port(write_port), .o_r_index(r_index),
        .i_read_port(read_port),
        .o_inv_en(inv_en), .o_inv_op(inv_op), .o_inv_asid(inv_asid), .o_inv_vpn(inv_vpn)
    );

    always #5 clk = ~clk;

    function automatic bit hit(logic [88:0] en, logic [18:0] vppn, logic [9:0] asid);
        return en[88] && en[70:52] == vppn && (en[77] || en[87:78] == asid);
    endfunction

    function automatic logic [88:0] mk_ent(bit e, bit g, logic [9:0] asid, logic [18:0] vppn, logic [51:0] pg);
        return {e, asid, g, 6'd12, vppn, pg};
    endfunction

    // TLB array stand-in: combinational read, registered search, write on we
    assign read_port = mem[r_index];
    always @(posedge clk) begin
        if (we) mem[w_index] <= write_port;
        s1_found <= 1'b0;
        s1_index <= '0;
        if (s1_fetch)
            for (int i = 31; i >= 0; i--)
                if (hit(mem[i], s1_vppn, s1_asid)) begin
                    s1_found <= 1'b1;
                    s1_index <= 5'(i);
                end
    end

    // replacement counter as seen from outside: cycles since reset, modulo entry count
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(logic [2:0] code, logic [4:0] idx, logic [88:0] ent, logic [4:0] iop,
                                 logic [9:0] iasid, logic [18:0] ivpn, int lat, bit found,
                                 logic [4:0] ridx, bit err, logic [88:0] rent, int nwe, int ninv);
        vec_t v;
        v.code = code; v.idx = idx; v.ent = ent; v.iop = iop; v.iasid = iasid; v.ivpn = ivpn;
        v.lat = lat; v.found = found; v.ridx = ridx; v.err = err; v.rent = rent; v.nwe = nwe; v.ninv = ninv;
        return v;
    endfunction

    function automatic vec_t predict(vec_t vin, logic [4:0] fill);
        vec_t v = vin;
        v.lat   = v.code == 0 ? 3 : v.code > 4 ? 1 : 2;
        v.err   = v.code > 4 || (v.code == 4 && v.iop > 6);
        v.found = 0; v.ridx = 0; v.rent = '0;
        v.nwe   = (v.code == 2 || v.code == 3) ? 1 : 0;
        v.ninv  = (v.code == 4 && v.iop <= 6) ? 1 : 0;
        if (v.code == 0)
            for (int i = 31; i >= 0; i--)
                if (hit(ref_mem[i], v.ent[70:52], v.ent[87:78])) begin
                    v.found = 1;
                    v.ridx = 5'(i);
                end
        if (v.code == 1) v.rent = ref_mem[v.idx];
        if (v.code == 2) v.ridx = v.idx;
        if (v.code == 3) v.ridx = fill;
        return v;
    endfunction

    task automatic do_op(input vec_t vin, input bit use_model, output logic [4:0] ridx_out);
        vec_t v = vin;
        logic [4:0] fill, widx;
        int k = 1, nwe = 0, ninv = 0, rdy_bad = 0;
        bit got = 0;
        chk("ready_idle", op_ready, 1);
        fill = 5'(cyc % 32);
        if (use_model) v = predict(v, fill);
        else if (v.code == 3) v.ridx = fill;
        widx = v.code == 3 ? fill : v.idx;
        op_code = v.code; op_index = v.idx; op_entry = v.ent;
        inv_op_i = v.iop; inv_asid_i = v.iasid; inv_vpn_i = v.ivpn;
        op_valid = 1;
        step;
        op_valid = 0;
        while (!got && k <= 8) begin
            if (we) begin
                nwe++;
                chk("w_index", w_index, widx);
                chk("write_port", write_port, v.ent);
            end
            if (inv_en) begin
                ninv++;
                chk("inv_fields", {inv_op, inv_asid, inv_vpn}, {v.iop, v.iasid, v.ivpn});
            end
            if (resp_valid) got = 1;
            else begin
                if (op_ready) rdy_bad++;
                step;
                k++;
            end
        end
        chk("latency", got ? k : -1, v.lat);
        chk("ready_low", rdy_bad, 0);
        chk("resp_err", resp_err, v.err);
        chk("resp_found", resp_found, v.found);
        chk("resp_index", resp_index, v.ridx);
        chk("resp_entry", resp_entry, v.rent);
        chk("we_count", nwe, v.nwe);
        chk("inv_count", ninv, v.ninv);
        ridx_out = resp_index;
        step;
        chk("resp_pulse", {resp_valid, op_ready}, 2'b01);
        chk("resp_hold", {resp_err, resp_index}, {v.err, v.ridx});
        if (v.code == 2) ref_mem[v.idx] = v.ent;
        if (v.code == 3) ref_mem[fill] = v.ent;
    endtask

    logic [88:0] e5, e9;
    logic [4:0]  ri, i2, i3;
    vec_t        tbl [10];
    vec_t        rv;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        e5 = mk_ent(1, 0, 10'd3, 19'h01234, 52'habc);
        e9 = mk_ent(1, 1, 10'd1, 19'h00999, 52'h5);
        rst = 1; op_valid = 0; op_code = 0; op_index = 0; op_entry = '0;
        inv_op_i = 0; inv_asid_i = 0; inv_vpn_i = 0;
        dmmu_fetch = 0; dmmu_vppn = 0; dmmu_odd = 0; dmmu_asid = 0;
        step;
        step;
        chk("rst_ready", op_ready, 1);
        chk("rst_pulses", {resp_valid, we, inv_en, dmmu_stall}, 4'b0);
        chk("rst_resp", {resp_found, resp_err, resp_index}, 7'b0);
        chk("rst_entry", resp_entry, 89'b0);
        rst = 0;

        do_op(mkv(3, 0, mk_ent(0, 0, 0, 19'h00042, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, ri);
        chk("fill_after_reset", ri, 0);

        tbl[0] = mkv(2, 5, e5, 0, 0, 0, 2, 0, 5, 0, '0, 1, 0);
        tbl[1] = mkv(1, 5, '0, 0, 0, 0, 2, 0, 0, 0, e5, 0, 0);
        tbl[2] = mkv(0, 0, mk_ent(0, 0, 10'd3, 19'h01234, 0), 0, 0, 0, 3, 1, 5, 0, '0, 0, 0);
        tbl[3] = mkv(0, 0, mk_ent(0, 0, 10'd3, 19'h7ffff, 0), 0, 0, 0, 3, 0, 0, 0, '0, 0, 0);
        tbl[4] = mkv(0, 0, mk_ent(0, 0, 10'd5, 19'h01234, 0), 0, 0, 0, 3, 0, 0, 0, '0, 0, 0);
        tbl[5] = mkv(4, 0, '0, 4, 10'd7, 19'h00222, 2, 0, 0, 0, '0, 0, 1);
        tbl[6] = mkv(4, 0, '0, 9, 10'd7, 19'h00222, 2, 0, 0, 1, '0, 0, 0);
        tbl[7] = mkv(6, 0, '0, 0, 0, 0, 1, 0, 0, 1, '0, 0, 0);
        tbl[8] = mkv(7, 0, '0, 0, 0, 0, 1, 0, 0, 1, '0, 0, 0);
        tbl[9] = mkv(1, 31, '0, 0, 0, 0, 2, 0, 0, 0, '0, 0, 0);
        for (int i = 0; i < 10; i++) do_op(tbl[i], 0, ri);

        // search while the data MMU keeps requesting the port
        op_code = 0; op_entry = mk_ent(0, 0, 10'd3, 19'h01234, 0);
        dmmu_vppn = 19'h00055; dmmu_asid = 10'd1; dmmu_odd = 1; dmmu_fetch = 1;
        op_valid = 1;
        step;
        op_valid = 0;
        chk("srch_t1_stall", dmmu_stall, 1);
        chk("srch_t1_s1", {s1_fetch, s1_odd, s1_vppn, s1_asid}, {2'b10, 19'h01234, 10'd3});
        dmmu_fetch = 0;
        step;
        chk("srch_t2", {dmmu_stall, s1_fetch, resp_valid}, 3'b100);
        dmmu_fetch = 1;
        step;
        chk("srch_t3_resp", {resp_valid, resp_found, resp_index}, {2'b11, 5'd5});
        chk("srch_t3_pass", {dmmu_stall, s1_fetch, s1_odd, s1_vppn, s1_asid}, {3'b011, 19'h00055, 10'd1});
        dmmu_fetch = 0; dmmu_odd = 0;
        step;

        // replacement counter wrap and spacing
        for (int n = 0; n < 40 && cyc % 32 != 31; n++) step;
        do_op(mkv(3, 0, e9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, ri);
        chk("fill_31", ri, 31);
        do_op(mkv(3, 0, e9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, i2);
        do_op(mkv(3, 0, e9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, i3);
        chk("fill_spacing", 5'(i3 - i2), 3);

        // reset while a write is in flight
        op_code = 2; op_index = 9; op_entry = e9; op_valid = 1;
        step;
        op_valid = 0;
        chk("abort_we", we, 1);
        ref_mem[9] = e9;
        rst = 1;
        step;
        rst = 0;
        chk("abort_idle", {op_ready, resp_valid, we, inv_en, dmmu_stall}, 5'b10000);
        step;
        chk("abort_noresp", {resp_valid, we}, 2'b00);

        for (int n = 0; n < 200; n++) begin
            rv = mkv(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                     mk_ent(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 3)),
                            19'($urandom_range(0, 7)), 52'($urandom)),
                     5'($urandom_range(0, 9)), 10'($urandom), 19'($urandom), 0, 0, 0, 0, '0, 0, 0);
            do_op(rv, 1, ri);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
